// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and default sizes for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int ARB_N_REQ     = 4;
  localparam int ARB_DATA_W    = 8;
  localparam int ARB_MAX_BURST = 4;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin picker (doubled-vector rotate and priority encode)
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = ARB_N_REQ,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic             any,
  output logic [ID_W-1:0]  winner
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [ID_W:0]      start;
  logic [ID_W:0]      offset;
  logic [ID_W+1:0]    sum;

  // Rotate so the slot after 'last' sits at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    start  = {1'b0, last} + (ID_W+1)'(1);
    dbl    = {req, req};
    rot    = N_REQ'(dbl >> start);
    any    = |req;
    offset = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) offset = (ID_W+1)'(i);
    end
    sum = {1'b0, start} + {1'b0, offset};
    if (sum >= (ID_W+2)'(N_REQ)) sum = sum - (ID_W+2)'(N_REQ);
    winner = sum[ID_W-1:0];
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = ARB_N_REQ,
  parameter int DATA_W    = ARB_DATA_W,
  parameter int MAX_BURST = ARB_MAX_BURST,
  localparam int ID_W     = $clog2(N_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      buf_full,
  output logic                      wr_en,
  output logic [DATA_W-1:0]         buf_in,
  output logic [N_REQ-1:0]          grant,
  output logic [ID_W-1:0]           owner_id,
  output logic                      busy
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  arb_state_t        state, state_next;
  logic [N_REQ-1:0]  grant_next;
  logic [ID_W-1:0]   owner_next;
  logic [ID_W-1:0]   last_owner, last_next;
  logic              busy_next;
  logic [CNT_W-1:0]  beat_cnt, cnt_next;

  logic              pick_any;
  logic [ID_W-1:0]   pick_id;
  logic              owner_valid;
  logic              accept;
  logic [DATA_W-1:0] owner_data;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req    (req_valid),
    .last   (last_owner),
    .any    (pick_any),
    .winner (pick_id)
  );

  // Owner handshake and zero-latency data path straight onto the FIFO write port.
  always_comb begin
    owner_valid = req_valid[owner_id];
    owner_data  = req_data[int'(owner_id)*DATA_W +: DATA_W];
    req_ready   = '0;
    accept      = 1'b0;
    buf_in      = '0;
    if (state == BURST) begin
      req_ready = grant & {N_REQ{!buf_full}};
      accept    = owner_valid && !buf_full;
      buf_in    = owner_data;
    end
    wr_en = accept;
  end

  // Next-state logic: arbitrate in IDLE, count beats and detect burst end in BURST.
  always_comb begin
    state_next = state;
    grant_next = grant;
    owner_next = owner_id;
    last_next  = last_owner;
    busy_next  = busy;
    cnt_next   = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_next = BURST;
          grant_next = N_REQ'(1) << pick_id;
          owner_next = pick_id;
          busy_next  = 1'b1;
          cnt_next   = '0;
        end
      end
      BURST: begin
        // A full FIFO with valid still high stalls: neither branch below fires.
        if (!owner_valid || (accept && beat_cnt == LAST_BEAT)) begin
          state_next = IDLE;
          grant_next = '0;
          last_next  = owner_id;
          busy_next  = 1'b0;
          cnt_next   = '0;
        end else if (accept) begin
          cnt_next = beat_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State registers; last_owner starts at the top index so requester 0 wins first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      owner_id   <= '0;
      last_owner <= ID_W'(N_REQ - 1);
      busy       <= 1'b0;
      beat_cnt   <= '0;
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      owner_id   <= owner_next;
      last_owner <= last_next;
      busy       <= busy_next;
      beat_cnt   <= cnt_next;
    end
  end

endmodule
